// File: rtl/dvv_trx_recorder.sv
// dvv_trx_recorder: passive valid/ready stream recorder.
// Transfers seen while capturing are timestamped and pushed into a small FIFO.
// The FIFO is read first-word-fall-through from the monitor side.
// Overflow either drops the transfer and counts it, or halts capture.
module dvv_trx_recorder #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int TSW   = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mon_vld,
    input  logic                     mon_rdy,
    input  logic [DW-1:0]            mon_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     halt_on_full,
    input  logic                     rd_req,
    output logic                     rd_vld,
    output logic [DW-1:0]            rd_data,
    output logic [TSW-1:0]           rd_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [15:0]              drop_cnt,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [TSW-1:0]    ts_q;
    logic              ovf_q;
    logic [15:0]       drop_cnt_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;

    logic [DW-1:0]     mem_data_q [DEPTH];
    logic [TSW-1:0]    mem_ts_q   [DEPTH];

    logic              xfer_s;
    logic              full_s;
    logic              pop_s;
    logic              cap_s;
    logic              wr_s;
    logic              ovf_ev_s;
    logic              start_tr_s;

    // Decode the handshake and the FIFO events of this cycle.
    always_comb begin
        xfer_s     = mon_vld & mon_rdy;
        full_s     = (level_q == LW'(DEPTH));
        pop_s      = rd_req & (level_q != {LW{1'b0}});
        cap_s      = (state_q == ST_CAP);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_s       = cap_s & xfer_s & (~full_s | pop_s);
        ovf_ev_s   = cap_s & xfer_s & full_s & ~pop_s;
        // Stop wins over start; start is only honoured from IDLE.
        start_tr_s = (state_q == ST_IDLE) & start & ~stop;
    end

    // Capture FSM with timestamp counter and overflow bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ts_q       <= {TSW{1'b0}};
            ovf_q      <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_tr_s) begin
                        state_q    <= ST_CAP;
                        ts_q       <= {TSW{1'b0}};
                        ovf_q      <= 1'b0;
                        drop_cnt_q <= 16'h0000;
                    end
                end
                ST_CAP: begin
                    ts_q <= ts_q + TSW'(1);
                    if (ovf_ev_s) begin
                        ovf_q <= 1'b1;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                    end
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (ovf_ev_s && halt_on_full) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents are meaningless whenever level is zero.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_data_q[wr_ptr_q] <= mon_data;
            mem_ts_q[wr_ptr_q]   <= ts_q;
        end
    end

    assign rd_vld   = (level_q != {LW{1'b0}});
    assign rd_data  = mem_data_q[rd_ptr_q];
    assign rd_ts    = mem_ts_q[rd_ptr_q];
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_dvv_trx_recorder.sv
// Table-driven bench for dvv_trx_recorder with a data/timestamp scoreboard.
module tb_dvv_trx_recorder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mon_vld, mon_rdy;
    logic [31:0] mon_data;
    logic        start, stop, halt_on_full, rd_req;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic [15:0] rd_ts;
    logic [3:0]  level;
    logic        ovf;
    logic [15:0] drop_cnt;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        start, stop, vld, rdy, hof, rd, push;
        logic [31:0] data;
        logic [15:0] pts;
        logic [3:0]  lvl;
        logic [1:0]  st;
        logic        ovf;
        logic [15:0] drop;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [15:0] t;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    dvv_trx_recorder #(.DW(32), .DEPTH(8), .TSW(16)) dut (
        .clk(clk), .resetn(resetn), .mon_vld(mon_vld), .mon_rdy(mon_rdy),
        .mon_data(mon_data), .start(start), .stop(stop),
        .halt_on_full(halt_on_full), .rd_req(rd_req), .rd_vld(rd_vld),
        .rd_data(rd_data), .rd_ts(rd_ts), .level(level), .ovf(ovf),
        .drop_cnt(drop_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // st sp vld rdy data hof rd push pts | lvl state ovf drop
    task automatic add(input int st, input int sp, input int v, input int r, input int d,
                       input int h, input int rq, input int p, input int pts,
                       input int lvl, input int s, input int o, input int dr);
        vec_t e;
        e.start = st[0]; e.stop = sp[0]; e.vld = v[0]; e.rdy = r[0];
        e.data = 32'(d); e.hof = h[0]; e.rd = rq[0]; e.push = p[0];
        e.pts = 16'(pts); e.lvl = 4'(lvl); e.st = 2'(s); e.ovf = o[0];
        e.drop = 16'(dr);
        vecs.push_back(e);
    endtask

    task automatic apply(input vec_t e);
        sb_t h;
        @(negedge clk);
        start = e.start; stop = e.stop; mon_vld = e.vld; mon_rdy = e.rdy;
        mon_data = e.data; halt_on_full = e.hof; rd_req = e.rd;
        if (e.push) sb.push_back('{e.data, e.pts});
        #1;
        if (e.rd && sb.size() > 0) begin
            h = sb.pop_front();
            chk("head_vld", 32'(rd_vld), 32'd1);
            chk("rd_data", rd_data, h.d);
            chk("rd_ts", 32'(rd_ts), 32'(h.t));
        end
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(e.lvl));
        chk("state", 32'(state_o), 32'(e.st));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
        chk("rd_vld", 32'(rd_vld), (e.lvl != 4'd0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_table();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        resetn = 1'b0; mon_vld = 1'b0; mon_rdy = 1'b0; mon_data = 32'd0;
        start = 1'b0; stop = 1'b0; halt_on_full = 1'b0; rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic capture and drain, then a pop on an empty FIFO.
        add(1,0,0,0,0,     0,0,0,0, 0,1,0,0);
        add(0,0,1,1,'hA,   0,0,1,0, 1,1,0,0);
        add(0,0,1,1,'hB,   0,0,1,1, 2,1,0,0);
        add(0,0,1,1,'hC,   0,0,1,2, 3,1,0,0);
        add(0,1,0,0,0,     0,0,0,0, 3,0,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,1,0,0, 2-i,0,0,0);
        add(0,0,0,0,0,     0,1,0,0, 0,0,0,0);

        // Drop mode overflow; half handshakes are not transfers.
        add(1,0,0,0,0,     0,0,0,0, 0,1,0,0);
        add(0,0,1,0,'hEE,  0,0,0,0, 0,1,0,0);
        add(0,0,0,1,'hEF,  0,0,0,0, 0,1,0,0);
        for (int i = 0; i < 8; i++) add(0,0,1,1,'h10+i, 0,0,1,2+i, i+1,1,0,0);
        add(0,0,1,1,'h18,  0,0,0,0, 8,1,1,1);
        add(0,0,1,1,'h19,  0,0,0,0, 8,1,1,2);
        add(0,1,0,0,0,     0,0,0,0, 8,0,1,2);

        // Restart with a full FIFO: write plus pop is accepted without overflow.
        add(1,0,0,0,0,     0,0,0,0, 8,1,0,0);
        add(0,0,1,1,'h20,  0,1,1,0, 8,1,0,0);
        for (int i = 0; i < 8; i++) add(0,0,0,0,0, 0,1,0,0, 7-i,1,0,0);
        add(0,1,0,0,0,     0,0,0,0, 0,0,0,0);

        // Halt mode overflow, start ignored in HALT, drain after stop.
        add(1,0,0,0,0,     1,0,0,0, 0,1,0,0);
        for (int i = 0; i < 8; i++) add(0,0,1,1,'h30+i, 1,0,1,i, i+1,1,0,0);
        add(0,0,1,1,'h38,  1,0,0,0, 8,2,1,1);
        add(0,0,1,1,'h39,  1,0,0,0, 8,2,1,1);
        add(1,0,0,0,0,     1,0,0,0, 8,2,1,1);
        add(0,0,0,0,0,     1,1,0,0, 7,2,1,1);
        add(0,1,0,0,0,     0,0,0,0, 7,0,1,1);
        for (int i = 0; i < 7; i++) add(0,0,0,0,0, 0,1,0,0, 6-i,0,1,1);

        // Stop beats start; transfers in IDLE are not recorded.
        add(1,1,0,0,0,     0,0,0,0, 0,0,1,1);
        add(0,0,1,1,'h77,  0,0,0,0, 0,0,1,1);

        // Build up five entries for the reset test.
        add(1,0,0,0,0,     0,0,0,0, 0,1,0,0);
        for (int i = 0; i < 5; i++) add(0,0,1,1,'h40+i, 0,0,1,i, i+1,1,0,0);
        run_table();

        // Asynchronous reset mid-capture, checked without any clock edge.
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_rd_vld", 32'(rd_vld), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;

        // After reset capture resumes only on a new start, from pointer zero.
        add(0,0,1,1,'h50,  0,0,0,0, 0,0,0,0);
        add(1,0,0,0,0,     0,0,0,0, 0,1,0,0);
        add(0,0,1,1,'h55,  0,0,1,0, 1,1,0,0);
        add(0,0,0,0,0,     0,1,0,0, 0,1,0,0);
        run_table();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
